// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, FSM state
// encodings, ALU operation codes, next-PC select codes and instruction classes.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_XOR   = 6'b010011;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b111;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_HALT, C_NOP
  } cls_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control <-> fetch-stage link: PC/IR write controls one way, the latched
// instruction and ALU flags the other.
interface multicycle_ctrl_if;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        IRWre;
  logic [31:0] IRInstruction;
  logic        zero;
  logic        sign;

  modport master (output PCWre, PCSrc, IRWre, input IRInstruction, zero, sign);
  modport slave  (input PCWre, PCSrc, IRWre, output IRInstruction, zero, sign);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode decoder: instruction class for the FSM plus the datapath selects,
// which are purely a function of the opcode (and flags for branch targets).
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               sign,
  output cls_e               cls,
  output logic               ext_sel,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               db_data_src,
  output logic [1:0]         reg_dst,
  output logic               wr_reg_d_src,
  output logic [1:0]         pc_src
);

  // Opcode to class and selects; unknown opcodes fall out as nop.
  always_comb begin
    cls          = C_NOP;
    ext_sel      = 1'b1;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    db_data_src  = 1'b0;
    reg_dst      = 2'b00;
    wr_reg_d_src = 1'b0;
    pc_src       = PC_NEXT;
    case (op)
      OP_ADD:   begin cls = C_ALU_R; alu_op = ALU_ADD; end
      OP_SUB:   begin cls = C_ALU_R; alu_op = ALU_SUB; end
      OP_AND:   begin cls = C_ALU_R; alu_op = ALU_AND; end
      OP_XOR:   begin cls = C_ALU_R; alu_op = ALU_XOR; end
      OP_SLT:   begin cls = C_ALU_R; alu_op = ALU_SLT; end
      OP_SLL:   begin cls = C_ALU_R; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_ADDIU: begin cls = C_ALU_I; alu_op = ALU_ADD; end
      OP_ANDI:  begin cls = C_ALU_I; alu_op = ALU_AND; ext_sel = 1'b0; end
      OP_ORI:   begin cls = C_ALU_I; alu_op = ALU_OR;  ext_sel = 1'b0; end
      OP_SLTI:  begin cls = C_ALU_I; alu_op = ALU_SLT; end
      OP_SW:    begin cls = C_SW; alu_src_b = 1'b1; end
      OP_LW:    begin cls = C_LW; alu_src_b = 1'b1; reg_dst = 2'b01;
                      db_data_src = 1'b1; wr_reg_d_src = 1'b1; end
      OP_BEQ:   begin cls = C_BR; alu_op = ALU_SUB; pc_src = zero  ? PC_BRANCH : PC_NEXT; end
      OP_BNE:   begin cls = C_BR; alu_op = ALU_SUB; pc_src = !zero ? PC_BRANCH : PC_NEXT; end
      OP_BLTZ:  begin cls = C_BR; alu_op = ALU_SUB; pc_src = sign  ? PC_BRANCH : PC_NEXT; end
      OP_J:     begin cls = C_J;   pc_src = PC_JUMP; end
      OP_JAL:   begin cls = C_JAL; pc_src = PC_JUMP; end
      OP_JR:    begin cls = C_JR;  pc_src = PC_RS; end
      OP_HALT:  cls = C_HALT;
      default:  cls = C_NOP;
    endcase
    if (cls == C_ALU_R) begin
      reg_dst      = 2'b10;
      wr_reg_d_src = 1'b1;
    end
    if (cls == C_ALU_I) begin
      reg_dst      = 2'b01;
      alu_src_b    = 1'b1;
      wr_reg_d_src = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences each instruction through its states,
// issues exactly one PCWre pulse in the instruction's last state, and gates all
// outputs low while reset is asserted.
//
//  state    | meaning
//  S_IF     | fetch: latch instruction into IR
//  S_ID     | decode; j/jal/jr/nop finish here; also parks here when halted
//  S_EXE_LS | address calc for lw/sw
//  S_MEM    | memory access (sw finishes)
//  S_WB_LD  | lw write-back
//  S_EXE_BR | branch compare and PC update
//  S_EXE_AL | ALU execute
//  S_WB_AL  | ALU write-back
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  fetch,
  output logic               ExtSel,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic [2:0]         state
);

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  logic   pc_wre, ir_wre, reg_wre, m_rd, m_wr;

  cls_e               cls;
  logic               ext_sel, alu_src_a, alu_src_b, db_data_src, wr_reg_d_src;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         reg_dst, pc_src;
  logic               unused_ir_bits;

  assign unused_ir_bits = ^fetch.IRInstruction[25:0];

  ctrl_decode u_decode (
    .op           (fetch.IRInstruction[31:26]),
    .zero         (fetch.zero),
    .sign         (fetch.sign),
    .cls          (cls),
    .ext_sel      (ext_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .db_data_src  (db_data_src),
    .reg_dst      (reg_dst),
    .wr_reg_d_src (wr_reg_d_src),
    .pc_src       (pc_src)
  );

  // State and halt flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Next state and per-state enables.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    pc_wre  = 1'b0;
    ir_wre  = 1'b0;
    reg_wre = 1'b0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (halt_q || cls == C_HALT) begin
          halt_d = 1'b1;
        end else begin
          case (cls)
            C_ALU_R, C_ALU_I: state_d = S_EXE_AL;
            C_LW, C_SW:       state_d = S_EXE_LS;
            C_BR:             state_d = S_EXE_BR;
            C_JAL: begin
              pc_wre  = 1'b1;
              reg_wre = 1'b1;
              state_d = S_IF;
            end
            default: begin
              pc_wre  = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        state_d = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (cls == C_SW) begin
          m_wr    = 1'b1;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end else begin
          m_rd    = 1'b1;
          state_d = S_WB_LD;
        end
      end
      S_WB_LD: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        pc_wre  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset gates every output combinationally so an aborted instruction
  // cannot leak a write strobe in the cycle reset falls.
  assign fetch.PCWre = rst & pc_wre;
  assign fetch.IRWre = rst & ir_wre;
  assign fetch.PCSrc = rst ? pc_src : 2'b00;
  assign RegWre      = rst & reg_wre;
  assign mRD         = rst & m_rd;
  assign mWR         = rst & m_wr;
  assign ExtSel      = rst & ext_sel;
  assign ALUSrcA     = rst & alu_src_a;
  assign ALUSrcB     = rst & alu_src_b;
  assign ALUOp       = rst ? alu_op : '0;
  assign DBDataSrc   = rst & db_data_src;
  assign RegDst      = rst ? reg_dst : 2'b00;
  assign WrRegDSrc   = rst & wr_reg_d_src;
  assign state       = state_q;

endmodule
